// File: rtl/popcount_seq_if.sv
// -----------------------------------------------------------------------------
// popcount_seq_if
//
// Handshake bundle for the sequenced population-count engine.
//
//   Word side (producer -> engine)
//     in_valid   in_data / in_last are valid
//     in_ready   engine accepts a word this cycle
//     in_data    12-bit word to count
//     in_last    word closes the current frame
//
//   Result side (engine -> consumer)
//     out_valid  frame result available
//     out_ready  consumer takes the result
//     out_count  total ones in the frame, saturated at 2^ACC_W-1
//     out_sat    saturation happened somewhere in the frame
//
// Modports:
//   master  the environment: drives words, consumes results
//   slave   the engine itself
// -----------------------------------------------------------------------------
interface popcount_seq_if #(
  parameter int ACC_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_data;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_count,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_count,
    output out_sat
  );

endinterface : popcount_seq_if

// File: rtl/popcount_seq.sv
// -----------------------------------------------------------------------------
// popcount_seq
//
// Sequenced population-count engine. Each accepted 12-bit word is counted one
// nibble per clock (high nibble first) through a single shared 4-bit lookup,
// and the per-nibble counts are accumulated across a frame of words that ends
// with the word flagged in_last. The frame total is then presented on the
// result handshake and held until the consumer takes it.
//
// Parameters:
//   ACC_W      accumulator / result width (>= 4); the total clamps at
//              2^ACC_W-1 and out_sat flags that the clamp was hit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        popcount_seq_if.slave: word input handshake + result handshake
//   busy       engine is not idle
//
// Timing summary:
//   A word occupies three cycles (N2, N1, N0). Non-last words can be accepted
//   back to back in N0, so a held in_valid streams one word every 3 cycles.
//   A last word accepted in cycle T shows out_valid from T+4.
// -----------------------------------------------------------------------------
module popcount_seq #(
  parameter int ACC_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  popcount_seq_if.slave  bus,
  output logic           busy
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_N2,    // counting word_q[11:8]
    S_N1,    // counting word_q[7:4]
    S_N0,    // counting word_q[3:0]; may accept the next word of the frame
    S_OUT    // result presented, waiting for out_ready
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // ---------------------------------------------------------------------------
  // Shared nibble lookup: number of set bits in a 4-bit value (0..4)
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] nib_ones(input logic [3:0] nib);
    logic [2:0] n;
    unique case (nib)
      4'h0:                         n = 3'd0;
      4'h1, 4'h2, 4'h4, 4'h8:       n = 3'd1;
      4'h3, 4'h5, 4'h6, 4'h9,
      4'hA, 4'hC:                   n = 3'd2;
      4'h7, 4'hB, 4'hD, 4'hE:       n = 3'd3;
      4'hF:                         n = 3'd4;
      default:                      n = 3'd0;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [11:0]      word_q;
  logic             last_q;
  logic [ACC_W-1:0] acc;
  logic             sat_q;

  // Controller outputs (combinational, decoded from registered state)
  logic             in_ready;
  logic             accept;
  logic             count_en;
  logic             frame_done;
  logic [3:0]       nib_sel;

  // Datapath
  logic [2:0]       nib_count;
  logic [ACC_W:0]   sum;
  logic             overflow;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update from pre-edge values; blocking (=) is reserved for
  // always_comb, where statements are meant to evaluate in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case statement,
  // so no path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    count_en   = 1'b0;
    frame_done = 1'b0;
    nib_sel    = 4'h0;

    // A new word may enter from IDLE, or in N0 when the word being finished
    // is not the end of its frame (the next word of the same frame).
    in_ready = (state == S_IDLE) || ((state == S_N0) && !last_q);
    accept   = bus.in_valid && in_ready;

    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_N2;
      end
      S_N2: begin
        count_en   = 1'b1;
        nib_sel    = word_q[11:8];
        state_next = S_N1;
      end
      S_N1: begin
        count_en   = 1'b1;
        nib_sel    = word_q[7:4];
        state_next = S_N0;
      end
      S_N0: begin
        count_en = 1'b1;
        nib_sel  = word_q[3:0];
        if (last_q)      state_next = S_OUT;
        else if (accept) state_next = S_N2;
        else             state_next = S_IDLE;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          frame_done = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word capture
  // ---------------------------------------------------------------------------
  // NOTE: word_q/last_q are plain flops rather than a storage array, so they
  // take a reset value like the rest of the state; the engine's observable
  // state is then fully defined right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      word_q <= bus.in_data;
      last_q <= bus.in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulator
  // ---------------------------------------------------------------------------
  // One extra bit on the sum catches the carry out of the accumulator; that
  // carry is exactly "unclamped total exceeds 2^ACC_W-1".
  assign nib_count = nib_ones(nib_sel);
  assign sum       = {1'b0, acc} + {{(ACC_W-2){1'b0}}, nib_count};
  assign overflow  = sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (count_en) begin
      acc <= overflow ? ACC_MAX : sum[ACC_W-1:0];
      if (overflow) sat_q <= 1'b1;
    end else if (frame_done) begin
      // Result consumed: the next frame starts counting from zero.
      acc   <= '0;
      sat_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are glitch-free and
  // stay constant for the whole time the result is held in OUT.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_count = acc;
  assign bus.out_sat   = sat_q;
  assign busy          = (state != S_IDLE);

endmodule : popcount_seq

// File: tb/tb_popcount_seq.sv
// -----------------------------------------------------------------------------
// tb_popcount_seq
//
// Drives two engines in lockstep from the same stimulus: one at ACC_W = 16
// and one at ACC_W = 4, so the 4-bit instance exercises the saturation clamp
// with short frames. Expected frame totals come from counting the bits of
// every word sent and clamping the frame sum; latency and handshake timing
// are checked against cycle numbers recorded at each accept.
// -----------------------------------------------------------------------------
module tb_popcount_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        busy16;
  logic        busy4;

  popcount_seq_if #(.ACC_W(16)) b16 ();
  popcount_seq_if #(.ACC_W(4))  b4  ();

  assign b16.in_valid  = in_valid;
  assign b16.in_data   = in_data;
  assign b16.in_last   = in_last;
  assign b16.out_ready = out_ready;
  assign b4.in_valid   = in_valid;
  assign b4.in_data    = in_data;
  assign b4.in_last    = in_last;
  assign b4.out_ready  = out_ready;

  popcount_seq #(.ACC_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16),
    .busy  (busy16)
  );

  popcount_seq #(.ACC_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4),
    .busy  (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          cyc;
  logic [11:0] fq[$];      // words of the frame about to be sent
  int          acc_t[$];   // accept cycle of each word of the last frame

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // One clock: inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int ones(input logic [11:0] w);
    int n = 0;
    for (int i = 0; i < 12; i++) n += (w >> i) & 1;
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(b16.in_ready),  1);
    check({tag, "_vld"},   32'(b16.out_valid), 0);
    check({tag, "_cnt"},   32'(b16.out_count), 0);
    check({tag, "_sat"},   32'(b16.out_sat),   0);
    check({tag, "_busy"},  32'(busy16),        0);
    check({tag, "_cnt4"},  32'(b4.out_count),  0);
    check({tag, "_busy4"}, 32'(busy4),         0);
  endtask

  // Presents one word and waits (bounded) until it is accepted. Returns at
  // the falling edge of the following cycle, which is the word's N2 cycle.
  task automatic send_word(input logic [11:0] d, input logic l, output int t_acc);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!b16.in_ready && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) check("accept_timeout", 0, 1);
    t_acc = cyc;
    acc_t.push_back(cyc);
    step();
    // Junk on the word lines while in_valid is low must be ignored.
    in_valid = 1'b0;
    in_data  = 12'($urandom);
    in_last  = 1'($urandom);
    check("n2_rdy",  32'(b16.in_ready), 0);
    check("n2_busy", 32'(busy16),       1);
  endtask

  // Waits for the result of a frame whose last word was accepted at t_acc,
  // checks it against the clamped total, holds it for 'hold' cycles, then
  // completes the handshake.
  task automatic collect(input int total, input int t_acc, input int hold);
    int exp16, exp4, sat16, sat4;
    int guard = 0;
    exp16 = (total > 65535) ? 65535 : total;
    sat16 = (total > 65535) ? 1 : 0;
    exp4  = (total > 15) ? 15 : total;
    sat4  = (total > 15) ? 1 : 0;
    while (!b16.out_valid && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency",  32'(cyc - t_acc),    4);
    check("vld4",     32'(b4.out_valid),   1);
    check("out_rdy",  32'(b16.in_ready),   0);
    check("cnt16",    32'(b16.out_count),  32'(exp16));
    check("sat16",    32'(b16.out_sat),    32'(sat16));
    check("cnt4",     32'(b4.out_count),   32'(exp4));
    check("sat4",     32'(b4.out_sat),     32'(sat4));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      step();
      check("hold_vld", 32'(b16.out_valid), 1);
      check("hold_cnt", 32'(b16.out_count), 32'(exp16));
      check("hold_sat", 32'(b4.out_sat),    32'(sat4));
      check("hold_rdy", 32'(b16.in_ready),  0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_vld",  32'(b16.out_valid), 0);
    check("post_rdy",  32'(b16.in_ready),  1);
    check("post_busy", 32'(busy16),        0);
  endtask

  // Sends the words in fq as one frame. gap >= 0: fixed number of idle
  // cycles after each non-last word; gap < 0: random 0..5.
  task automatic run_frame(input int gap, input int hold);
    int t_acc = 0;
    int total = 0;
    int g;
    acc_t.delete();
    foreach (fq[i]) begin
      send_word(fq[i], (i == fq.size() - 1), t_acc);
      total += ones(fq[i]);
      if (i != fq.size() - 1) begin
        g = (gap < 0) ? $urandom_range(5, 0) : gap;
        repeat (g) step();
        if (g >= 3) check("gap_idle", 32'(busy16), 0);
      end
    end
    collect(total, t_acc, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not complete, expected finish at cycle %0d or earlier", 50000);
    $fatal(1, "global timeout");
  end

  initial begin
    int nw;
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #1;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_reset");

    // Single full word.
    fq = '{12'hFFF};
    run_frame(0, 0);

    // Three-word frame with in_valid held: accepts every 3 cycles.
    fq = '{12'h001, 12'h0F0, 12'hA5A};
    run_frame(0, 0);
    check("stream_t1", 32'(acc_t[1] - acc_t[0]), 3);
    check("stream_t2", 32'(acc_t[2] - acc_t[0]), 6);

    // Backpressure, then accumulator cleared for the next frame.
    fq = '{12'h777};
    run_frame(0, 5);
    fq = '{12'h001};
    run_frame(0, 0);

    // Saturation on the 4-bit instance, then a clean frame.
    fq = '{12'hFFF, 12'hFFF};
    run_frame(0, 0);
    fq = '{12'h003};
    run_frame(0, 0);

    // Zero word, and idle gaps between non-last words.
    fq = '{12'h000};
    run_frame(0, 0);
    fq = '{12'h0F0, 12'h00F, 12'h101};
    run_frame(6, 1);

    // Reset in N1 of the second word of a frame.
    begin
      int t;
      send_word(12'hFFF, 1'b0, t);
      send_word(12'h0FF, 1'b0, t);
      step();                       // N1 of second word
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        check("no_vld_after_reset", 32'(b16.out_valid), 0);
      end
      fq = '{12'h800};
      run_frame(0, 0);
    end

    // Randomized frames: random words (biased to all-ones and zero), random
    // gaps and random result backpressure.
    for (int f = 0; f < 40; f++) begin
      fq.delete();
      nw = $urandom_range(5, 1);
      for (int i = 0; i < nw; i++) begin
        case ($urandom_range(3, 0))
          0:       fq.push_back(12'hFFF);
          1:       fq.push_back(12'h000);
          default: fq.push_back(12'($urandom));
        endcase
      end
      run_frame(-1, $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_popcount_seq
